// File: rtl/mux_arb_reg.sv
// N-input registered selector with explicit-select and round-robin modes,
// per-input valid/ready handshakes and a one-entry output register.
module mux_arb_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    Mode,
    input  logic [SEL_W-1:0]        Sel,
    input  logic [NUM_IN-1:0]       InValid,
    output logic [NUM_IN-1:0]       InReady,
    input  logic [NUM_IN*WIDTH-1:0] DataIn,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [WIDTH-1:0]        DataOut,
    output logic [SEL_W-1:0]        OutSel
);

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_last;

    logic              w_space;
    logic              w_grant;
    logic [SEL_W-1:0]  w_grant_idx;
    logic [WIDTH-1:0]  w_grant_data;
    logic              w_transfer;

    // Reset also gates Space so no channel sees a handshake while reset is held.
    assign w_space    = Reset && (!r_valid || OutReady);
    assign w_transfer = w_grant && w_space;

    // Round-robin priority: channel i is (i - Last - 1) mod NUM_IN steps away
    // from the pointer; the valid channel with the smallest distance wins.
    always_comb begin
        int w_dist;
        int w_best;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_dist      = 0;
        w_best      = NUM_IN;
        if (!Mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (Sel == SEL_W'(i) && InValid[i]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                w_dist = i - int'(r_last) - 1;
                if (w_dist < 0) begin
                    w_dist = w_dist + NUM_IN;
                end
                if (InValid[i] && w_dist < w_best) begin
                    w_best      = w_dist;
                    w_grant     = 1'b1;
                    w_grant_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        InReady      = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_data = DataIn[i*WIDTH +: WIDTH];
                InReady[i]   = w_transfer;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from pre-edge values.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_last  <= SEL_W'(NUM_IN - 1);
        end else if (w_transfer) begin
            r_valid <= 1'b1;
            r_data  <= w_grant_data;
            r_sel   <= w_grant_idx;
            r_last  <= w_grant_idx;
        end else if (r_valid && OutReady) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end
    end

    assign OutValid = r_valid;
    assign DataOut  = r_data;
    assign OutSel   = r_sel;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench for mux_arb_reg: a transaction-level model compared
// every cycle, plus directed literal expectations from the test plan.
module tb_mux_arb_reg;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    logic                    CLK      = 1'b0;
    logic                    Reset    = 1'b0;
    logic                    Mode     = 1'b0;
    logic [SEL_W-1:0]        Sel      = '0;
    logic [NUM_IN-1:0]       InValid  = '0;
    logic [NUM_IN-1:0]       InReady;
    logic [NUM_IN*WIDTH-1:0] DataIn;
    logic                    OutValid;
    logic                    OutReady = 1'b0;
    logic [WIDTH-1:0]        DataOut;
    logic [SEL_W-1:0]        OutSel;

    logic [WIDTH-1:0] din [NUM_IN];

    int n_checks = 0;
    int n_errors = 0;

    mux_arb_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Mode     (Mode),
        .Sel      (Sel),
        .InValid  (InValid),
        .InReady  (InReady),
        .DataIn   (DataIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .DataOut  (DataOut),
        .OutSel   (OutSel)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        DataIn = '0;
        for (int i = 0; i < NUM_IN; i++) DataIn[i*WIDTH +: WIDTH] = din[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: output register contents and round-robin pointer.
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_sel   = 0;
    int               m_last  = NUM_IN - 1;
    logic             n_valid = 1'b0;
    logic [WIDTH-1:0] n_data  = '0;
    int               n_sel   = 0;
    int               n_last  = NUM_IN - 1;

    always @(negedge CLK) begin : model_cmp
        int   g;
        bit   ok;
        bit   space;
        logic [NUM_IN-1:0] exp_ready;
        g     = 0;
        ok    = 1'b0;
        space = !m_valid || OutReady;
        if (!Mode) begin
            g  = int'(Sel);
            ok = (g < NUM_IN) && InValid[g];
        end else begin
            for (int k = 1; k <= NUM_IN && !ok; k++) begin
                g  = (m_last + k) % NUM_IN;
                ok = InValid[g];
            end
        end
        exp_ready = (Reset && ok && space) ? NUM_IN'(1 << g) : '0;

        check("cyc_in_ready",  64'(InReady),  64'(exp_ready));
        check("cyc_out_valid", 64'(OutValid), 64'(m_valid));
        check("cyc_data_out",  64'(DataOut),  64'(m_data));
        check("cyc_out_sel",   64'(OutSel),   64'(m_sel));

        n_valid = m_valid; n_data = m_data; n_sel = m_sel; n_last = m_last;
        if (!Reset) begin
            n_valid = 1'b0; n_data = '0; n_sel = 0; n_last = NUM_IN - 1;
        end else if (exp_ready != '0) begin
            n_valid = 1'b1; n_data = din[g]; n_sel = g; n_last = g;
        end else if (m_valid && OutReady) begin
            n_valid = 1'b0; n_data = '0; n_sel = 0;
        end
    end

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = NUM_IN - 1;
        end else begin
            m_valid = n_valid; m_data = n_data; m_sel = n_sel; m_last = n_last;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic mode, input logic [SEL_W-1:0] sel,
                         input logic [NUM_IN-1:0] valid, input logic ordy);
        Mode = mode; Sel = sel; InValid = valid; OutReady = ordy;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic [SEL_W-1:0] s);
        check({tag, "_valid"}, 64'(OutValid), 64'(v));
        check({tag, "_data"},  64'(DataOut),  64'(d));
        check({tag, "_sel"},   64'(OutSel),   64'(s));
    endtask

    int exp_rr_a [6] = '{0, 1, 2, 3, 0, 1};
    int exp_rr_b [4] = '{3, 1, 3, 1};

    initial begin
        for (int i = 0; i < NUM_IN; i++) din[i] = 32'hCAFE_0000 + 32'(i);

        // 1. Reset holds everything idle while inputs toggle.
        for (int c = 0; c < 4; c++) begin
            step();
            drive(1'(c & 1), SEL_W'(c), NUM_IN'(c * 5 + 3), 1'((c >> 1) & 1));
            din[c] = $urandom;
            #1;
            chk_out("t1_rst", 1'b0, 32'h0, 2'd0);
            check("t1_rst_ready", 64'(InReady), 64'h0);
        end
        for (int i = 0; i < NUM_IN; i++) din[i] = 32'hCAFE_0000 + 32'(i);
        #1 Reset = 1'b1;
        drive(1'b0, 2'd2, 4'b0100, 1'b1);
        #1 check("t1_ready", 64'(InReady), 64'h4);
        step();
        chk_out("t1_out", 1'b1, 32'hCAFE_0002, 2'd2);
        drive(1'b0, 2'd2, 4'b0000, 1'b1);
        step();
        chk_out("t1_drain", 1'b0, 32'h0, 2'd0);

        // 2. Explicit select ignores other channels.
        drive(1'b0, 2'd1, 4'b1101, 1'b1);
        #1 check("t2_masked", 64'(InReady), 64'h0);
        step();
        check("t2_idle", 64'(OutValid), 64'h0);
        Sel = 2'd3;
        #1 check("t2_ready3", 64'(InReady), 64'h8);
        step();
        chk_out("t2_out", 1'b1, 32'hCAFE_0003, 2'd3);
        drive(1'b0, 2'd0, 4'b0000, 1'b1);
        step();

        // 3. Round-robin fairness from a fresh reset.
        #1 Reset = 1'b0;
        #1 Reset = 1'b1;
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int j = 0; j < 6; j++) begin
            step();
            check("t3_rr_sel", 64'(OutSel), 64'(exp_rr_a[j]));
            check("t3_rr_valid", 64'(OutValid), 64'h1);
        end
        InValid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            step();
            check("t3_rr2_sel", 64'(OutSel), 64'(exp_rr_b[j]));
            check("t3_rr2_valid", 64'(OutValid), 64'h1);
        end

        // 4. Back-pressure holds the word; release replaces it without a gap.
        din[1] = 32'h0000_0011;
        drive(1'b0, 2'd1, 4'b0010, 1'b1);
        step();
        chk_out("t4_load", 1'b1, 32'h0000_0011, 2'd1);
        drive(1'b1, 2'd0, 4'b1111, 1'b0);
        for (int j = 0; j < 3; j++) begin
            #1 check("t4_stall_ready", 64'(InReady), 64'h0);
            step();
            chk_out("t4_hold", 1'b1, 32'h0000_0011, 2'd1);
        end
        OutReady = 1'b1;
        #1 check("t4_release_ready", 64'(InReady), 64'h4);
        step();
        chk_out("t4_replace", 1'b1, 32'hCAFE_0002, 2'd2);

        // 5. Drain clears the output register.
        drive(1'b1, 2'd0, 4'b0000, 1'b1);
        step();
        chk_out("t5_drain", 1'b0, 32'h0, 2'd0);

        // 6. Asynchronous reset mid-stall; pointer restarts at channel 0.
        din[3] = 32'hDEAD_BEEF;
        drive(1'b0, 2'd3, 4'b1000, 1'b1);
        step();
        chk_out("t6_load", 1'b1, 32'hDEAD_BEEF, 2'd3);
        drive(1'b1, 2'd0, 4'b1111, 1'b0);
        step();
        chk_out("t6_stall", 1'b1, 32'hDEAD_BEEF, 2'd3);
        Reset = 1'b0;
        #1;
        chk_out("t6_async", 1'b0, 32'h0, 2'd0);
        check("t6_async_ready", 64'(InReady), 64'h0);
        Reset = 1'b1;
        #1 check("t6_first_grant", 64'(InReady), 64'h1);
        step();
        chk_out("t6_out", 1'b1, 32'hCAFE_0000, 2'd0);

        drive(1'b0, 2'd0, 4'b0000, 1'b1);
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
